mem_dbus_stage: RTL and testbench
=================================

// Module: mem_dbus_stage
// PURPOSE
//  MEM-stage unit directly downstream of the EX/MEM pipeline register. Consumes mem_aluop/mem_mem_addr/mem_reg2,
//  runs load/store on a req/ack data bus (big-endian byte lanes), stalls the pipeline until done, aligns and
//  sign/zero-extends load data, and forwards the result fields to MEM/WB. Non-memory ops pass through with 0 latency.
// PARAMETERS
//  DBUS_TIMEOUT  255  REQ-state cycles without dbus_ack before the access is aborted (1..2^TO_W-1)
//  TO_W          8    width of the timeout counter
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   synchronous, active-high reset (`RstEnable)
//  stall        in   6   ctrl stall vector; stall[4] gates MEM/WB advance
//  wd_i         in   5   dest reg addr from EX/MEM
//  wreg_i       in   1   GPR write enable from EX/MEM
//  wdata_i      in   32  ALU result from EX/MEM
//  whilo_i      in   1   HI/LO write enable; hi_i/lo_i in 32 each
//  aluop_i      in   8   op code (`EXE_LB_OP..`EXE_SW_OP decoded)
//  mem_addr_i   in   32  effective address; reg2_i in 32 store data
//  wd_o wreg_o wdata_o whilo_o hi_o lo_o  out  5/1/32/1/32/32  to MEM/WB
//  stallreq_o   out  1   pipeline stall request to ctrl
//  dbus_req_o   out  1   bus request, registered; held until ack/abort
//  dbus_we_o    out  1   1=store; dbus_addr_o out 32 word address {addr[31:2],2'b00}
//  dbus_sel_o   out  4   byte lanes, sel[3]=byte0 (bits 31:24)
//  dbus_wdata_o out  32  store data replicated to lanes (SB {4{b}}, SH {2{h}}, SW word)
//  dbus_ack_i   in   1   slave ack; dbus_rdata_i in 32 read data, valid with ack
//  bus_err_o    out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: state IDLE, dbus_req/we 0, dbus_addr/sel/wdata 0, timer 0, captured data 0, bus_err 0;
//   while rst high outputs forced wd=`NOPRegAddr, wreg=0, wdata/hi/lo=0, whilo=0, stallreq=0.
//  FSM IDLE->REQ->DONE->IDLE.
//  IDLE: non-mem op -> outputs = inputs combinationally, stallreq=0. Mem op -> stallreq=1 (combinational,
//   same cycle), register addr/sel/we/wdata, next REQ.
//  REQ: dbus_req=1, stallreq=1, timer++ each cycle. ack -> capture rdata, drop req, next DONE.
//   timer==DBUS_TIMEOUT and no ack -> drop req, bus_err pulse, next DONE with error flag. Ack same cycle
//   as timeout: ack wins, no error.
//  DONE: stallreq=0, outputs valid; -> IDLE when stall[4]==`NoStop, else hold DONE (no re-issue).
//  Min latency: ack in first REQ cycle -> 2 stall cycles, result to MEM/WB on 3rd edge.
//  Lane map (addr[1:0]): 00->sel 1000, 01->0100, 10->0010, 11->0001; LH/SH: 00->1100, 10->0011; LW/SW 1111.
//  Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW whole word; wdata_o=aligned value.
//  Stores: wreg_o=0, wdata_o=0. Error abort: wreg_o=0, wdata_o=0.
//  Reset mid-REQ: next edge IDLE, req dropped; a late ack in IDLE is ignored.
//  Passthrough of whilo/hi/lo unchanged for all ops.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 never issue on bus;
//   IDLE->DONE directly (1 stall cycle), bus_err_o pulses, wreg_o=0, misalign_o (out 1) high in DONE.
//  Not defined: no check, misalign_o absent; LH/SH use addr[1] only, LW/SW ignore addr[1:0].
// TESTING
//  LW addr 0x100, ack 1st REQ cycle, rdata 0xDEADBEEF -> stallreq 2 cycles, wdata_o 0xDEADBEEF, wreg_o 1.
//  LB addr 0x103, rdata 0x123456F0 -> sel 0001, wdata_o 0xFFFFFFF0; LBU same -> 0x000000F0.
//  SH addr 0x202, reg2 0x0000ABCD -> dbus_we 1, sel 0011, dbus_wdata 0xABCDABCD, wreg_o 0.
//  No ack, DBUS_TIMEOUT=4 -> req high 4 cycles, bus_err 1 pulse, wreg_o 0, stallreq drops after.
//  rst asserted in REQ -> next edge req 0, state IDLE; ack one cycle later causes no output change.
//  MEM_ALIGN_CHECK_EN, LW addr 0x101 -> no dbus_req, 1 stall cycle, misalign_o 1, bus_err pulse.

Source files
------------

// File: rtl/mem_dbus_stage_if.sv
// Data-bus interface between the MEM-stage unit and the memory slave.
// The master side (the stage) issues req/we/addr/sel/wdata; the slave
// returns ack with rdata valid in the same cycle.
interface mem_dbus_stage_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req,
    output dbus_we,
    output dbus_addr,
    output dbus_sel,
    output dbus_wdata,
    input  dbus_ack,
    input  dbus_rdata
  );

  modport slave (
    input  dbus_req,
    input  dbus_we,
    input  dbus_addr,
    input  dbus_sel,
    input  dbus_wdata,
    output dbus_ack,
    output dbus_rdata
  );
endinterface

// File: rtl/mem_dbus_stage.sv
// MEM-stage load/store unit sitting after the EX/MEM register.
// Memory ops are run on a req/ack bus with big-endian byte lanes while the
// pipeline is stalled; the aligned/extended load result is then handed to
// MEM/WB. Non-memory ops pass straight through with zero latency.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, misaligned
// halfword/word accesses are rejected without touching the bus and the
// misalign_o port is present.
module mem_dbus_stage #(
  parameter int unsigned DBUS_TIMEOUT = 255,
  parameter int unsigned TO_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic [4:0]           wd_i,
  input  logic                 wreg_i,
  input  logic [31:0]          wdata_i,
  input  logic                 whilo_i,
  input  logic [31:0]          hi_i,
  input  logic [31:0]          lo_i,
  input  logic [7:0]           aluop_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          reg2_i,
  output logic [4:0]           wd_o,
  output logic                 wreg_o,
  output logic [31:0]          wdata_o,
  output logic                 whilo_o,
  output logic [31:0]          hi_o,
  output logic [31:0]          lo_o,
  output logic                 stallreq_o,
  mem_dbus_stage_if.master     dbus,
  output logic                 bus_err_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                 misalign_o
`endif
);

  // Opcodes handled by this stage
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
  localparam logic       NO_STOP      = 1'b0;

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(DBUS_TIMEOUT);
  localparam logic [TO_W-1:0] TIMER_ONE = TO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Decode / datapath helpers
  // ---------------------------------------------------------------------
  function automatic logic is_load(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
      default:                                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
      default:                         is_store = 1'b0;
    endcase
  endfunction

  // Byte-lane enables; sel[3] is the lowest-addressed byte (bits 31:24)
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        case (a)
          2'b00:   lane_sel = 4'b1000;
          2'b01:   lane_sel = 4'b0100;
          2'b10:   lane_sel = 4'b0010;
          2'b11:   lane_sel = 4'b0001;
          default: lane_sel = 4'b0000;
        endcase
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: lane_sel = a[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:             lane_sel = 4'b1111;
      default:                          lane_sel = 4'b0000;
    endcase
  endfunction

  // Store data replicated onto every lane so the slave only has to honour sel
  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
    case (op)
      EXE_SB_OP: store_data = {4{d[7:0]}};
      EXE_SH_OP: store_data = {2{d[15:0]}};
      EXE_SW_OP: store_data = d;
      default:   store_data = 32'h0000_0000;
    endcase
  endfunction

  // Pick the addressed lane out of the bus word and sign/zero-extend it
  function automatic logic [31:0] load_align(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (a)
      2'b00:   byte_v = rd[31:24];
      2'b01:   byte_v = rd[23:16];
      2'b10:   byte_v = rd[15:8];
      2'b11:   byte_v = rd[7:0];
      default: byte_v = 8'h00;
    endcase
    half_v = a[1] ? rd[15:0] : rd[31:16];
    case (op)
      EXE_LB_OP:  load_align = {{24{byte_v[7]}}, byte_v};
      EXE_LBU_OP: load_align = {24'h00_0000, byte_v};
      EXE_LH_OP:  load_align = {{16{half_v[15]}}, half_v};
      EXE_LHU_OP: load_align = {16'h0000, half_v};
      EXE_LW_OP:  load_align = rd;
      default:    load_align = 32'h0000_0000;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Halfwords need an even address, words a 4-byte aligned one
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = a[0];
      EXE_LW_OP, EXE_SW_OP:             misaligned = (a != 2'b00);
      default:                          misaligned = 1'b0;
    endcase
  endfunction
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       bwdata_q, bwdata_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [31:0]       load_q, load_d;
  logic [7:0]        op_q, op_d;
  logic [1:0]        alo_q, alo_d;
  logic              err_q, err_d;
  logic              bus_err_q, bus_err_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  logic mem_op_s;
  assign mem_op_s = is_load(aluop_i) | is_store(aluop_i);

  // Next-state and next-register computation for the bus access sequencer
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    bwdata_d  = bwdata_q;
    timer_d   = timer_q;
    load_d    = load_q;
    op_d      = op_q;
    alo_d     = alo_q;
    err_d     = err_q;
    bus_err_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          op_d  = aluop_i;
          alo_d = mem_addr_i[1:0];
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned(aluop_i, mem_addr_i[1:0])) begin
            // Rejected access: skip the bus and report straight away
            state_d    = S_DONE;
            err_d      = 1'b1;
            bus_err_d  = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d  = S_REQ;
            req_d    = 1'b1;
            we_d     = is_store(aluop_i);
            addr_d   = {mem_addr_i[31:2], 2'b00};
            sel_d    = lane_sel(aluop_i, mem_addr_i[1:0]);
            bwdata_d = store_data(aluop_i, reg2_i);
            timer_d  = TIMER_ONE;
            err_d    = 1'b0;
          end
`else
          state_d  = S_REQ;
          req_d    = 1'b1;
          we_d     = is_store(aluop_i);
          addr_d   = {mem_addr_i[31:2], 2'b00};
          sel_d    = lane_sel(aluop_i, mem_addr_i[1:0]);
          bwdata_d = store_data(aluop_i, reg2_i);
          timer_d  = TIMER_ONE;
          err_d    = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack in the timeout cycle still completes the access normally
        if (dbus.dbus_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          load_d  = load_align(op_q, alo_q, dbus.dbus_rdata);
          state_d = S_DONE;
        end else if (timer_q == TIMEOUT_V) begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          load_d    = 32'h0000_0000;
          err_d     = 1'b1;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_DONE: begin
        // Result is held (never re-issued) until MEM/WB is allowed to advance
        if (stall[4] == NO_STOP) begin
          state_d = S_IDLE;
          timer_d = {TO_W{1'b0}};
          err_d   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_d = 1'b0;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // Register all sequencer state and bus outputs; synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      sel_q     <= 4'b0000;
      bwdata_q  <= 32'h0000_0000;
      timer_q   <= {TO_W{1'b0}};
      load_q    <= 32'h0000_0000;
      op_q      <= 8'h00;
      alo_q     <= 2'b00;
      err_q     <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      bwdata_q  <= bwdata_d;
      timer_q   <= timer_d;
      load_q    <= load_d;
      op_q      <= op_d;
      alo_q     <= alo_d;
      err_q     <= err_d;
      bus_err_q <= bus_err_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // MEM/WB-facing outputs and the stall request
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    whilo_o    = whilo_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o    = NOP_REG_ADDR;
      wreg_o  = 1'b0;
      wdata_o = 32'h0000_0000;
      whilo_o = 1'b0;
      hi_o    = 32'h0000_0000;
      lo_o    = 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A new memory op stalls in the same cycle it shows up
          if (mem_op_s) begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            wdata_o    = 32'h0000_0000;
          end else begin
            stallreq_o = 1'b0;
          end
        end
        S_REQ: begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          wdata_o    = 32'h0000_0000;
        end
        S_DONE: begin
          if (err_q || is_store(op_q)) begin
            wreg_o  = 1'b0;
            wdata_o = 32'h0000_0000;
          end else begin
            wdata_o = load_q;
          end
        end
        default: begin
          wreg_o  = 1'b0;
          wdata_o = 32'h0000_0000;
        end
      endcase
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_sel   = sel_q;
  assign dbus.dbus_wdata = bwdata_q;
  assign bus_err_o       = bus_err_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_o      = misalign_q;
`endif

  // Only stall[4] matters here; the other ctrl bits belong to earlier stages
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[3:0]};

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Directed, table-driven bench for mem_dbus_stage (DBUS_TIMEOUT=4).
module tb_mem_dbus_stage;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] SW  = 8'b1110_1011;
  localparam logic [7:0] NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i, lo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;
  logic        bus_err_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  mem_dbus_stage_if dbus_if();

  mem_dbus_stage #(.DBUS_TIMEOUT(4), .TO_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .whilo_i    (whilo_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o),
    .dbus       (dbus_if),
    .bus_err_o  (bus_err_o)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_o (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;

  // count cycles in which the stage requests a stall
  always @(negedge clk) begin
    if (stallreq_o) stall_cnt <= stall_cnt + 1;
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic [31:0] exp_busw;
    logic [31:0] exp_wdata;
    logic        exp_wreg;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } pt_t;

  vec_t vecs[11];
  pt_t  pts[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic go_idle_nop();
    aluop_i = NOP; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0000_0000;
    whilo_i = 1'b0; hi_i = 32'h0000_0000; lo_i = 32'h0000_0000;
    mem_addr_i = 32'h0000_0000; reg2_i = 32'h0000_0000;
  endtask

  // Issue one memory op from IDLE, ack after v.delay extra REQ cycles
  task automatic run_vec(input vec_t v, input int idx);
    int s0;
    string tag;
    tag = $sformatf("v%0d", idx);
    s0 = stall_cnt;
    aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h5555_0000;
    whilo_i = 1'b1; hi_i = 32'h0000_1111; lo_i = 32'h0000_2222;
    @(negedge clk);
    chk({tag, "_stall_idle"}, {31'd0, stallreq_o}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_req"},  {31'd0, dbus_if.dbus_req}, 32'd1);
    chk({tag, "_addr"}, dbus_if.dbus_addr, v.exp_addr);
    chk({tag, "_sel"},  {28'd0, dbus_if.dbus_sel}, {28'd0, v.exp_sel});
    chk({tag, "_we"},   {31'd0, dbus_if.dbus_we}, {31'd0, v.exp_we});
    chk({tag, "_busw"}, dbus_if.dbus_wdata, v.exp_busw);
    for (int k = 0; k < v.delay; k++) begin
      @(posedge clk); #1;
    end
    dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = v.rdata;
    @(posedge clk); #1;
    dbus_if.dbus_ack = 1'b0; dbus_if.dbus_rdata = 32'h0000_0000;
    @(negedge clk);
    chk({tag, "_stall_done"}, {31'd0, stallreq_o}, 32'd0);
    chk({tag, "_req_done"},   {31'd0, dbus_if.dbus_req}, 32'd0);
    chk({tag, "_wreg"},  {31'd0, wreg_o}, {31'd0, v.exp_wreg});
    chk({tag, "_wdata"}, wdata_o, v.exp_wdata);
    chk({tag, "_wd"},    {27'd0, wd_o}, 32'd9);
    chk({tag, "_hi"},    hi_o, 32'h0000_1111);
    chk({tag, "_berr"},  {31'd0, bus_err_o}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_stall_cycles"}, stall_cnt - s0, 2 + v.delay);
    go_idle_nop();
  endtask

  initial begin
    int s0, req_cnt, err_cnt;
    bit done;

    //        op   addr          reg2          rdata         dly exp_addr      sel      we    busw          wdata         wreg
    vecs[0]  = '{LW,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1};
    vecs[1]  = '{LB,  32'h0000_0103, 32'h0,        32'h1234_56F0, 0, 32'h0000_0100, 4'b0001, 1'b0, 32'h0,        32'hFFFF_FFF0, 1'b1};
    vecs[2]  = '{LBU, 32'h0000_0103, 32'h0,        32'h1234_56F0, 0, 32'h0000_0100, 4'b0001, 1'b0, 32'h0,        32'h0000_00F0, 1'b1};
    vecs[3]  = '{SH,  32'h0000_0202, 32'h0000_ABCD, 32'h0,        0, 32'h0000_0200, 4'b0011, 1'b1, 32'hABCD_ABCD, 32'h0,        1'b0};
    vecs[4]  = '{LH,  32'h0000_0100, 32'h0,        32'h8001_1234, 1, 32'h0000_0100, 4'b1100, 1'b0, 32'h0,        32'hFFFF_8001, 1'b1};
    vecs[5]  = '{LHU, 32'h0000_0102, 32'h0,        32'h8001_9234, 0, 32'h0000_0100, 4'b0011, 1'b0, 32'h0,        32'h0000_9234, 1'b1};
    vecs[6]  = '{SB,  32'h0000_0101, 32'h1234_56A5, 32'h0,        0, 32'h0000_0100, 4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h0,        1'b0};
    vecs[7]  = '{SW,  32'h0000_010C, 32'hCAFE_F00D, 32'h0,        2, 32'h0000_010C, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0,        1'b0};
    vecs[8]  = '{LB,  32'h0000_0101, 32'h0,        32'h127F_5678, 0, 32'h0000_0100, 4'b0100, 1'b0, 32'h0,        32'h0000_007F, 1'b1};
    vecs[9]  = '{LW,  32'h0000_00FC, 32'h0,        32'h0123_4567, 3, 32'h0000_00FC, 4'b1111, 1'b0, 32'h0,        32'h0123_4567, 1'b1};
    vecs[10] = '{LB,  32'h0000_0102, 32'h0,        32'h0000_8000, 0, 32'h0000_0100, 4'b0010, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b1};

    pts[0] = '{8'b0010_0101, 5'd7,  1'b1, 32'h1357_9BDF, 1'b0, 32'hAAAA_0000, 32'hBBBB_0000};
    pts[1] = '{8'b0010_0000, 5'd31, 1'b0, 32'hFFFF_0001, 1'b1, 32'h0000_00AA, 32'h0000_00BB};
    pts[2] = '{8'b0001_0001, 5'd1,  1'b1, 32'h0000_0000, 1'b1, 32'h8000_0000, 32'h0000_0001};

    // reset with non-trivial inputs: outputs must be forced
    rst = 1'b1; stall = 6'd0;
    dbus_if.dbus_ack = 1'b0; dbus_if.dbus_rdata = 32'h0000_0000;
    aluop_i = pts[0].op; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h1234_5678;
    whilo_i = 1'b1; hi_i = 32'h1; lo_i = 32'h2; mem_addr_i = 32'h0; reg2_i = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wd",     {27'd0, wd_o}, 32'd0);
    chk("rst_wreg",   {31'd0, wreg_o}, 32'd0);
    chk("rst_wdata",  wdata_o, 32'd0);
    chk("rst_whilo",  {31'd0, whilo_o}, 32'd0);
    chk("rst_stall",  {31'd0, stallreq_o}, 32'd0);
    chk("rst_req",    {31'd0, dbus_if.dbus_req}, 32'd0);
    chk("rst_sel",    {28'd0, dbus_if.dbus_sel}, 32'd0);
    chk("rst_addr",   dbus_if.dbus_addr, 32'd0);
    chk("rst_berr",   {31'd0, bus_err_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // non-memory passthrough, zero latency
    for (int i = 0; i < 3; i++) begin
      aluop_i = pts[i].op; wd_i = pts[i].wd; wreg_i = pts[i].wreg; wdata_i = pts[i].wdata;
      whilo_i = pts[i].whilo; hi_i = pts[i].hi; lo_i = pts[i].lo;
      @(negedge clk);
      chk($sformatf("pt%0d_wd", i),    {27'd0, wd_o}, {27'd0, pts[i].wd});
      chk($sformatf("pt%0d_wreg", i),  {31'd0, wreg_o}, {31'd0, pts[i].wreg});
      chk($sformatf("pt%0d_wdata", i), wdata_o, pts[i].wdata);
      chk($sformatf("pt%0d_whilo", i), {31'd0, whilo_o}, {31'd0, pts[i].whilo});
      chk($sformatf("pt%0d_hi", i),    hi_o, pts[i].hi);
      chk($sformatf("pt%0d_lo", i),    lo_o, pts[i].lo);
      chk($sformatf("pt%0d_stall", i), {31'd0, stallreq_o}, 32'd0);
      @(posedge clk); #1;
    end
    go_idle_nop();
    @(posedge clk); #1;

    // table of bus accesses
    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i);
    end

    // timeout abort: no ack at all
    s0 = stall_cnt; req_cnt = 0; err_cnt = 0; done = 1'b0;
    aluop_i = LW; mem_addr_i = 32'h0000_0300; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1111_1111;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (dbus_if.dbus_req) req_cnt++;
      if (bus_err_o) err_cnt++;
      if (i > 0 && !stallreq_o) begin
        done = 1'b1;
        chk("to_wreg",  {31'd0, wreg_o}, 32'd0);
        chk("to_wdata", wdata_o, 32'd0);
        chk("to_berr",  {31'd0, bus_err_o}, 32'd1);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("to_completed", {31'd0, done}, 32'd1);
    chk("to_req_cycles", req_cnt, 4);
    chk("to_berr_cycles", err_cnt, 1);
    @(posedge clk); #1;
    chk("to_stall_cycles", stall_cnt - s0, 5);
    go_idle_nop();
    @(negedge clk);
    chk("to_berr_pulse_end", {31'd0, bus_err_o}, 32'd0);
    @(posedge clk); #1;

    // reset during REQ, then a late ack in IDLE
    aluop_i = LW; mem_addr_i = 32'h0000_0400; wd_i = 5'd4; wreg_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("mrst_wreg",  {31'd0, wreg_o}, 32'd0);
    chk("mrst_wd",    {27'd0, wd_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    go_idle_nop();
    wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'h7777_0001;
    dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mrst_req_dropped", {31'd0, dbus_if.dbus_req}, 32'd0);
    chk("mrst_idle_stall",  {31'd0, stallreq_o}, 32'd0);
    chk("mrst_idle_wdata",  wdata_o, 32'h7777_0001);
    @(posedge clk); #1;
    dbus_if.dbus_ack = 1'b0; dbus_if.dbus_rdata = 32'h0000_0000;
    @(negedge clk);
    chk("late_ack_req",   {31'd0, dbus_if.dbus_req}, 32'd0);
    chk("late_ack_berr",  {31'd0, bus_err_o}, 32'd0);
    chk("late_ack_wdata", wdata_o, 32'h7777_0001);
    chk("late_ack_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    go_idle_nop();

    // DONE held by stall[4]: result stays, nothing re-issued
    aluop_i = LBU; mem_addr_i = 32'h0000_0103; wd_i = 5'd9; wreg_i = 1'b1;
    @(posedge clk); #1;
    dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = 32'h1234_56F0;
    @(posedge clk); #1;
    dbus_if.dbus_ack = 1'b0; dbus_if.dbus_rdata = 32'h0000_0000;
    stall = 6'b01_0000;
    @(negedge clk);
    chk("hold0_wdata", wdata_o, 32'h0000_00F0);
    @(posedge clk); #1;
    stall = 6'd0;
    @(negedge clk);
    chk("hold1_wdata", wdata_o, 32'h0000_00F0);
    chk("hold1_req",   {31'd0, dbus_if.dbus_req}, 32'd0);
    chk("hold1_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    go_idle_nop();
    wdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    chk("hold_exit_wdata", wdata_o, 32'h0BAD_F00D);
    chk("hold_exit_req",   {31'd0, dbus_if.dbus_req}, 32'd0);
    @(posedge clk); #1;
    go_idle_nop();

`ifdef MEM_ALIGN_CHECK_EN
    // misaligned word: rejected without a bus cycle
    s0 = stall_cnt;
    aluop_i = LW; mem_addr_i = 32'h0000_0101; wd_i = 5'd2; wreg_i = 1'b1;
    @(negedge clk);
    chk("mis_stall_idle", {31'd0, stallreq_o}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_req",      {31'd0, dbus_if.dbus_req}, 32'd0);
    chk("mis_stall",    {31'd0, stallreq_o}, 32'd0);
    chk("mis_flag",     {31'd0, misalign_o}, 32'd1);
    chk("mis_berr",     {31'd0, bus_err_o}, 32'd1);
    chk("mis_wreg",     {31'd0, wreg_o}, 32'd0);
    @(posedge clk); #1;
    chk("mis_stall_cycles", stall_cnt - s0, 1);
    go_idle_nop();
    @(negedge clk);
    chk("mis_flag_clear", {31'd0, misalign_o}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
